demux_fifo: RTL and testbench

Four-way demultiplexer with per-channel buffering. Takes one input word stream with a valid/ready handshake and routes each accepted word to one of four output channels, chosen by a 2-bit selector. Each channel holds up to two words in a first-word-fall-through buffer with its own valid/pop handshake. The block sits on the distribution side of the datapath, feeding the four lanes that the 4:1 multiplexer later recombines.

---
 rtl/demux_fifo_pkg.sv | 24 ++
 rtl/demux_fifo_fifo2.sv | 77 +++++++
 rtl/demux_fifo.sv | 53 +++++
 tb/tb_demux_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/demux_fifo_pkg.sv
// Shared constants for the demux_fifo block: channel count, selector width
// and the per-channel occupancy encodings.
`ifndef DEMUX_FIFO_PKG_SV
`define DEMUX_FIFO_PKG_SV
package demux_fifo_pkg;

  localparam int NUM_CANALES = 4;
  localparam int SEL_BITS    = 2;

  typedef logic [1:0] estado_t;

  localparam estado_t VACIO = 2'd0;
  localparam estado_t UNO   = 2'd1;
  localparam estado_t LLENO = 2'd2;

  function automatic logic [NUM_CANALES-1:0] decode_sel(input logic [SEL_BITS-1:0] sel);
    logic [NUM_CANALES-1:0] onehot;
    onehot = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage
`endif

// File: rtl/demux_fifo_fifo2.sv
// Two-entry first-word-fall-through buffer; head is always the oldest word.
// Supports write and read in the same cycle, also when full.
//
// state | meaning
// VACIO | no words held, dout forced to 0
// UNO   | head valid
// LLENO | head and tail valid
module fifo2
  import demux_fifo_pkg::*;
#(
  parameter int DATA_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 vacio,
  output logic                 lleno
);

  estado_t              state_q, state_d;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic [DATA_BITS-1:0] tail_q, tail_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      VACIO: begin
        if (wr) begin
          state_d = UNO;
          head_d  = din;
        end
      end
      UNO: begin
        case ({wr, rd})
          2'b10: begin
            state_d = LLENO;
            tail_d  = din;
          end
          2'b01: state_d = VACIO;
          2'b11: head_d  = din;
          default: ;
        endcase
      end
      LLENO: begin
        // A write without a read is blocked upstream by listo.
        if (rd) begin
          head_d = tail_q;
          if (wr) tail_d = din;
          else    state_d = UNO;
        end
      end
      default: state_d = VACIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= VACIO;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign vacio = (state_q == VACIO);
  assign lleno = (state_q == LLENO);
  assign dout  = vacio ? '0 : head_q;

endmodule

// File: rtl/demux_fifo.sv
// Four-way demultiplexer: routes each accepted word to the channel on
// selector, each channel buffered by its own fifo2.
module demux_fifo
  import demux_fifo_pkg::*;
#(
  parameter int DATA_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   enb,
  input  logic [DATA_BITS-1:0]   entrada,
  input  logic [SEL_BITS-1:0]    selector,
  input  logic                   valid_in,
  output logic                   listo,
  output logic [DATA_BITS-1:0]   salida0,
  output logic [DATA_BITS-1:0]   salida1,
  output logic [DATA_BITS-1:0]   salida2,
  output logic [DATA_BITS-1:0]   salida3,
  output logic [NUM_CANALES-1:0] valid_out,
  input  logic [NUM_CANALES-1:0] pop
);

  logic [NUM_CANALES-1:0] vacio_w;
  logic [NUM_CANALES-1:0] lleno_w;
  logic [NUM_CANALES-1:0] wr_w;
  logic [DATA_BITS-1:0]   salida_w [NUM_CANALES];
  logic                   acc;

  // Pass-through ready: a full channel accepts when its head leaves this cycle.
  assign listo = reset_L && enb && (!lleno_w[selector] || pop[selector]);
  assign acc   = valid_in && listo;
  assign wr_w  = acc ? decode_sel(selector) : '0;

  for (genvar n = 0; n < NUM_CANALES; n++) begin : g_canal
    fifo2 #(.DATA_BITS(DATA_BITS)) u_fifo2 (
      .clk     (clk),
      .reset_L (reset_L),
      .wr      (wr_w[n]),
      .din     (entrada),
      .rd      (pop[n]),
      .dout    (salida_w[n]),
      .vacio   (vacio_w[n]),
      .lleno   (lleno_w[n])
    );
  end

  assign valid_out = ~vacio_w;
  assign salida0   = salida_w[0];
  assign salida1   = salida_w[1];
  assign salida2   = salida_w[2];
  assign salida3   = salida_w[3];

endmodule

// File: tb/tb_demux_fifo.sv
// Directed and randomised checks of demux_fifo; a queue model per channel
// tracks the 8-bit instance every cycle, directed steps check the 4-bit one.
module tb_demux_fifo;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enb;
  logic [7:0] ent8;
  logic [1:0] sel;
  logic       valid_in;
  logic [3:0] pop;

  logic       listo4, listo8;
  logic [3:0] valid4, valid8;
  logic [3:0] s4 [4];
  logic [7:0] s8 [4];

  logic [7:0] mq [4][$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_fifo #(.DATA_BITS(4)) dut4 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .entrada(ent8[3:0]),
    .selector(sel), .valid_in(valid_in), .listo(listo4),
    .salida0(s4[0]), .salida1(s4[1]), .salida2(s4[2]), .salida3(s4[3]),
    .valid_out(valid4), .pop(pop)
  );

  demux_fifo #(.DATA_BITS(8)) dut8 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .entrada(ent8),
    .selector(sel), .valid_in(valid_in), .listo(listo8),
    .salida0(s8[0]), .salida1(s8[1]), .salida2(s8[2]), .salida3(s8[3]),
    .valid_out(valid8), .pop(pop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare the 8-bit instance with the model, advance the model
  // with the inputs that the coming edge will see, then step past the edge.
  task automatic tick();
    logic exp_l;
    @(negedge clk);
    if (!reset_L) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      chk("m_rst_valid", 32'(valid8), 32'd0);
      chk("m_rst_listo", 32'(listo8), 32'd0);
    end else begin
      for (int n = 0; n < 4; n++) begin
        chk("m_valid", 32'(valid8[n]), 32'(mq[n].size() != 0));
        chk("m_salida", 32'(s8[n]), (mq[n].size() != 0) ? 32'(mq[n][0]) : 32'd0);
      end
      exp_l = enb && (mq[sel].size() != 2 || pop[sel]);
      chk("m_listo", 32'(listo8), 32'(exp_l));
      for (int n = 0; n < 4; n++) begin
        if (pop[n] && mq[n].size() != 0) void'(mq[n].pop_front());
        if (valid_in && exp_l && sel == 2'(n)) mq[n].push_back(ent8);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] ch, input logic [3:0] v);
    sel = ch; ent8 = {4'hC, v}; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    reset_L = 1'b0; enb = 1'b1; ent8 = '0; sel = '0; valid_in = 1'b0; pop = '0;
    #1;
    chk("rst_valid", 32'(valid4), 32'd0);
    chk("rst_listo", 32'(listo4), 32'd0);
    repeat (2) tick();
    reset_L = 1'b1;

    // Reset mid-stream
    put(2'd2, 4'hA);
    chk("t1_pre_salida2", 32'(s4[2]), 32'hA);
    put(2'd0, 4'h3);
    reset_L = 1'b0;
    #1;
    chk("t1_async_valid", 32'(valid4), 32'd0);
    chk("t1_async_salida0", 32'(s4[0]), 32'd0);
    chk("t1_async_salida2", 32'(s4[2]), 32'd0);
    chk("t1_async_listo", 32'(listo4), 32'd0);
    tick();
    reset_L = 1'b1;
    put(2'd2, 4'hA);
    chk("t1_salida2", 32'(s4[2]), 32'hA);
    chk("t1_valid", 32'(valid4), 32'b0100);
    pop = 4'b0100; tick(); pop = '0;
    chk("t1_pop_valid", 32'(valid4), 32'd0);

    // Fill and backpressure
    put(2'd0, 4'h1);
    put(2'd0, 4'h2);
    sel = 2'd0; ent8 = 8'hC3; valid_in = 1'b1;
    #1;
    chk("t2_listo_full", 32'(listo4), 32'd0);
    sel = 2'd3;
    #1;
    chk("t2_listo_sel3", 32'(listo4), 32'd1);
    sel = 2'd0;
    tick();
    chk("t2_held_salida0", 32'(s4[0]), 32'h1);
    chk("t2_held_valid", 32'(valid4), 32'b0001);
    pop = 4'b0001;
    #1;
    chk("t2_listo_pop", 32'(listo4), 32'd1);
    tick();
    valid_in = 1'b0; pop = '0;
    chk("t2_salida0", 32'(s4[0]), 32'h2);
    pop = 4'b0001; tick();
    chk("t2_drain_salida0", 32'(s4[0]), 32'h3);
    tick(); pop = '0;
    chk("t2_drain_valid", 32'(valid4), 32'd0);

    // Full-channel write with pop
    put(2'd1, 4'h5);
    put(2'd1, 4'h6);
    sel = 2'd1; ent8 = 8'hC7; valid_in = 1'b1; pop = 4'b0010;
    tick();
    valid_in = 1'b0; pop = '0;
    chk("t3_salida1", 32'(s4[1]), 32'h6);
    #1;
    chk("t3_still_full", 32'(listo4), 32'd0);
    pop = 4'b0010; tick();
    chk("t3_salida1_7", 32'(s4[1]), 32'h7);
    chk("t3_valid_one", 32'(valid4), 32'b0010);
    tick(); pop = '0;
    chk("t3_empty", 32'(valid4), 32'd0);

    // Simultaneous pops
    put(2'd0, 4'h8);
    put(2'd1, 4'h9);
    put(2'd2, 4'hA);
    put(2'd3, 4'hB);
    chk("t4_valid_all", 32'(valid4), 32'b1111);
    chk("t4_salida3", 32'(s4[3]), 32'hB);
    pop = 4'b1111; tick(); pop = '0;
    chk("t4_valid_none", 32'(valid4), 32'd0);
    for (int n = 0; n < 4; n++) chk("t4_salida_zero", 32'(s4[n]), 32'd0);

    // Enable
    put(2'd3, 4'h4);
    enb = 1'b0; sel = 2'd0; ent8 = 8'hCE; valid_in = 1'b1;
    #1;
    chk("t5_listo_off", 32'(listo4), 32'd0);
    repeat (3) tick();
    chk("t5_nothing_stored", 32'(valid4), 32'b1000);
    pop = 4'b1000; tick(); pop = '0;
    chk("t5_pop_valid", 32'(valid4), 32'd0);
    chk("t5_pop_salida3", 32'(s4[3]), 32'd0);
    enb = 1'b1;
    #1;
    chk("t5_listo_on", 32'(listo4), 32'd1);
    tick();
    valid_in = 1'b0;
    chk("t5_resume_salida0", 32'(s4[0]), 32'hE);
    chk("t5_resume_valid", 32'(valid4), 32'b0001);
    pop = 4'b0001; tick(); pop = '0;

    // Randomised ordering on the 8-bit instance
    for (int i = 0; i < 200; i++) begin
      enb      = ($urandom_range(0, 7) != 0);
      valid_in = $urandom_range(0, 1) == 1;
      sel      = 2'($urandom_range(0, 3));
      ent8     = 8'($urandom);
      pop      = 4'($urandom) & 4'($urandom);
      tick();
    end
    valid_in = 1'b0; pop = 4'b1111;
    repeat (3) tick();
    pop = '0;
    tick();
    chk("t6_drained_valid", 32'(valid8), 32'd0);
    for (int n = 0; n < 4; n++) chk("t6_model_empty", 32'(mq[n].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
